mem8_arbiter: RTL and testbench
===============================

Name: mem8_arbiter

Overview:
- Two-port arbiter and access sequencer for the external 8-bit asynchronous SRAM (16-bit address, bidirectional 8-bit data, cs/oe/we).
- Sits between two on-chip requesters (e.g. the test sequencer and a LED/display reader) and the SRAM pins.
- Grants one requester at a time with round-robin fairness, generates setup/strobe/hold timing, and returns read data with a one-cycle ack pulse.

Parameters:
- WAIT_CYCLES, 2: strobe length in clk cycles (we or oe high); legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- p0_req / p1_req  input  1  access request; held high until ack.
- p0_wr / p1_wr  input  1  1 = write, 0 = read; valid while req high.
- p0_addr / p1_addr  input  16  access address; valid while req high.
- p0_wdata / p1_wdata  input  8  write data; valid while req high.
- p0_rdata / p1_rdata  output  8  read data; valid from the ack cycle until that port's next read completes.
- p0_ack / p1_ack  output  1  one-cycle completion pulse (reads and writes).
- mem_addr  output  16  SRAM address.
- mem_data  inout  8  SRAM data; driven only when the current access is a write.
- mem_cs  output  1  chip select, active-high; high in SETUP, ACCESS and HOLD.
- mem_oe  output  1  output enable, active-high.
- mem_we  output  1  write enable, active-high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, mem_data tri-stated, state IDLE, last_grant = 1 (port 0 wins the first contention).
- Reset mid-operation takes effect immediately (asynchronous). Strobes drop, the bus releases, no ack is issued and the access is abandoned.
- All SRAM-side outputs and acks are registered. No combinational path from req to pins.
- States:
  - IDLE: sample reqs. If any is high, pick the winner, latch wr/addr/wdata into internal registers, drive mem_addr, update last_grant, go to SETUP.
  - Winner selection: if only one req is high, that port wins. If both are high, the port != last_grant wins.
  - SETUP (1 cycle): mem_cs=1, mem_addr valid, we=oe=0. Write: mem_data driven with latched wdata. Load wait counter with WAIT_CYCLES-1, go to ACCESS.
  - ACCESS (WAIT_CYCLES cycles): write has mem_we=1 with data driven; read has mem_oe=1 with bus released. Counter decrements.
  - ACCESS exit: on the edge leaving ACCESS with counter==0, a read captures mem_data into the granted port's rdata. Go to HOLD.
  - HOLD (1 cycle): we=oe=0, cs=1, address and write data still driven (hold time). Granted port's ack=1. Go to IDLE.
  - IDLE after HOLD: cs=0, bus released.
- Latency: ack is high during the cycle beginning WAIT_CYCLES+2 edges after the IDLE edge that granted the request. Minimum request-to-request period per port is WAIT_CYCLES+3 cycles.
- Requester contract: keep req and its fields stable until ack is seen, and drop req at the edge ending the ack cycle.
  - The arbiter does not re-sample req in HOLD, so no double grant occurs.
  - A req dropped before ack is ignored; the latched access still completes and acks.
- Changes to the non-granted port's inputs during an access have no effect. Its pending req is served next.
- mem_oe and mem_we are never high in the same cycle. mem_data is never driven while mem_oe=1.
- Wait counter is 8 bits. WAIT_CYCLES=1 gives exactly one strobe cycle. Address is passed through unmodified, with no wrap logic.

Optional Feature:
- Macro: MEM8_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins contention. last_grant is still updated but ignored, so port 1 can starve.
- Undefined (default): round-robin as described above.

Test Plan:
- Single write, WAIT_CYCLES=2: p0 write addr 0x1234, data 0xA5.
  - Response: SETUP with mem_data=0xA5 and we=0; mem_we high for exactly 2 cycles; HOLD with data still driven; p0_ack pulse 4 cycles after the grant edge.
- Read-back: p0 read 0x1234 from an SRAM model holding 0xA5.
  - Response: mem_oe high 2 cycles; mem_data tri-stated by the arbiter throughout; p0_rdata=0xA5 in the ack cycle; p1_rdata unchanged.
- Contention: p0 and p1 both request from reset and re-request immediately after each ack, for 6 accesses.
  - Response: grant order p0,p1,p0,p1,p0,p1, each 5 cycles apart.
  - With MEM8_ARB_FIXED_PRIO_EN defined: p0 only.
- Minimum strobe, WAIT_CYCLES=1: alternating write/read at 0xFFFF, data 0x3C.
  - Response: one-cycle strobes; readback 0x3C; we and oe never overlap.
- Reset mid-ACCESS of a p1 write: assert rst asynchronously.
  - Response: mem_we, mem_cs and busy drop without waiting for an edge; bus goes Z; no p1_ack.
  - After release, a new p0 request is granted first.
- Late req drop: p1 deasserts req during SETUP.
  - Response: the access still completes, p1_ack pulses once, and no second grant is issued.

Source files
------------

// File: rtl/mem8_arbiter.sv
// mem8_arbiter: two-port arbiter and access sequencer for an external 8-bit
// asynchronous SRAM (16-bit address, bidirectional data, cs/oe/we strobes).
//
// Each access runs IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles)
// -> HOLD (1 cycle, ack) -> IDLE. Contention is resolved round-robin.
// Every SRAM-side pin and every ack comes straight from a flop.
//
// Ports:
//   clk, rst                  clock (rising edge) and async active-high reset
//   pN_req_i/wr_i/addr_i/wdata_i  request, direction (1=write), address, data
//   pN_rdata_o, pN_ack_o      read data (held until next read), 1-cycle ack
//   mem_addr_o, mem_data_io   SRAM address and bidirectional data
//   mem_cs_o/oe_o/we_o        SRAM strobes, active-high
//   busy_o                    high whenever the sequencer is not IDLE
//
// Build option: define MEM8_ARB_FIXED_PRIO_EN to give port 0 fixed priority
// on contention (port 1 can then starve). Default is round-robin.
module mem8_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_i,
  input  logic        p0_wr_i,
  input  logic [15:0] p0_addr_i,
  input  logic [7:0]  p0_wdata_i,
  output logic [7:0]  p0_rdata_o,
  output logic        p0_ack_o,
  input  logic        p1_req_i,
  input  logic        p1_wr_i,
  input  logic [15:0] p1_addr_i,
  input  logic [7:0]  p1_wdata_i,
  output logic [7:0]  p1_rdata_o,
  output logic        p1_ack_o,
  output logic [15:0] mem_addr_o,
  inout  wire  [7:0]  mem_data_io,
  output logic        mem_cs_o,
  output logic        mem_oe_o,
  output logic        mem_we_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        drive_q, drive_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        win_s;

  // Winner of the current IDLE sample (only meaningful when a req is high)
  always_comb begin
    if (p0_req_i && p1_req_i) begin
`ifdef MEM8_ARB_FIXED_PRIO_EN
      win_s = 1'b0;
`else
      win_s = ~last_grant_q;
`endif
    end else if (p1_req_i) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next state, latched access fields and next values of the pin registers.
  // Pin values are computed for the state being entered so the flops present
  // them during that state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cs_d         = 1'b0;
    oe_d         = 1'b0;
    we_d         = 1'b0;
    drive_d      = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          gnt_d        = win_s;
          last_grant_d = win_s;
          wr_d         = win_s ? p1_wr_i    : p0_wr_i;
          addr_d       = win_s ? p1_addr_i  : p0_addr_i;
          wdata_d      = win_s ? p1_wdata_i : p0_wdata_i;
          cs_d         = 1'b1;
          drive_d      = win_s ? p1_wr_i    : p0_wr_i;
          state_d      = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        cnt_d   = 8'(WAIT_CYCLES - 1);
        cs_d    = 1'b1;
        drive_d = wr_q;
        we_d    = wr_q;
        oe_d    = ~wr_q;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        cs_d    = 1'b1;
        drive_d = wr_q;
        if (cnt_q == 8'd0) begin
          // Last strobe cycle: oe is still high, so the SRAM is driving now
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = ST_HOLD;
          if (!wr_q && gnt_q) begin
            rdata1_d = mem_data_io;
          end else if (!wr_q) begin
            rdata0_d = mem_data_io;
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          cnt_d   = cnt_q - 8'd1;
          we_d    = wr_q;
          oe_d    = ~wr_q;
          state_d = ST_ACCESS;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pin registers; reset releases the bus and drops strobes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      cnt_q        <= 8'h00;
      cs_q         <= 1'b0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      drive_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cs_q         <= cs_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      drive_q      <= drive_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign mem_data_io = drive_q ? wdata_q : 8'bzzzz_zzzz;
  assign mem_addr_o  = addr_q;
  assign mem_cs_o    = cs_q;
  assign mem_oe_o    = oe_q;
  assign mem_we_o    = we_q;
  assign p0_ack_o    = ack0_q;
  assign p1_ack_o    = ack1_q;
  assign p0_rdata_o  = rdata0_q;
  assign p1_rdata_o  = rdata1_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem8_arbiter.sv
// Self-checking bench for mem8_arbiter: transaction-level reference model,
// SRAM model on the pins, directed scenarios plus randomized traffic, and a
// second instance with WAIT_CYCLES=1 for the minimum-strobe case.
module tb_mem8_arbiter;
  localparam int W = 2;
`ifdef MEM8_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        rq_req   [2];
  logic        rq_wr    [2];
  logic [15:0] rq_addr  [2];
  logic [7:0]  rq_wdata [2];
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;
  logic        mem_cs, mem_oe, mem_we, busy;

  logic [7:0]  sram    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  assign mem_data = mem_oe ? sram[mem_addr] : 8'bzzzz_zzzz;

  mem8_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .p0_req_i(rq_req[0]), .p0_wr_i(rq_wr[0]), .p0_addr_i(rq_addr[0]), .p0_wdata_i(rq_wdata[0]),
    .p0_rdata_o(p0_rdata), .p0_ack_o(p0_ack),
    .p1_req_i(rq_req[1]), .p1_wr_i(rq_wr[1]), .p1_addr_i(rq_addr[1]), .p1_wdata_i(rq_wdata[1]),
    .p1_rdata_o(p1_rdata), .p1_ack_o(p1_ack),
    .mem_addr_o(mem_addr), .mem_data_io(mem_data),
    .mem_cs_o(mem_cs), .mem_oe_o(mem_oe), .mem_we_o(mem_we), .busy_o(busy)
  );

  // Second instance, WAIT_CYCLES=1, port 1 idle, single-byte SRAM at 0xFFFF
  logic        d1_req, d1_wr;
  logic [7:0]  d1_wdata, d1_rdata, d1_rdata1, s1;
  logic        d1_ack, d1_ack1, d1_cs, d1_oe, d1_we, d1_busy;
  logic [15:0] d1_addr;
  wire  [7:0]  d1_data;
  assign d1_data = d1_oe ? s1 : 8'bzzzz_zzzz;

  mem8_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .p0_req_i(d1_req), .p0_wr_i(d1_wr), .p0_addr_i(16'hFFFF), .p0_wdata_i(d1_wdata),
    .p0_rdata_o(d1_rdata), .p0_ack_o(d1_ack),
    .p1_req_i(1'b0), .p1_wr_i(1'b0), .p1_addr_i(16'h0000), .p1_wdata_i(8'h00),
    .p1_rdata_o(d1_rdata1), .p1_ack_o(d1_ack1),
    .mem_addr_o(d1_addr), .mem_data_io(d1_data),
    .mem_cs_o(d1_cs), .mem_oe_o(d1_oe), .mem_we_o(d1_we), .busy_o(d1_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m_k = cycles elapsed since the granting edge (0 = idle)
  int          m_k;
  int          t_port;
  logic        t_wr;
  logic [15:0] t_addr;
  logic [7:0]  t_wdata;
  int          last;
  logic [7:0]  exp_rd [2];
  int          cyc;
  int          grant_port_q [$];
  int          grant_cyc_q  [$];
  bit          pending [2];
  int          mode;          // 0 directed, 1 re-request on ack, 2 random
  int          ack_cnt [2];
  int          ack_cyc [2];
  int          we_cnt, oe_cnt;
  logic [7:0]  setup_data, hold_data;
  logic        setup_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic clear_obs();
    grant_port_q.delete();
    grant_cyc_q.delete();
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0;
    we_cnt = 0; oe_cnt = 0;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [15:0] a, input logic [7:0] d);
    rq_req[p] = 1'b1; rq_wr[p] = wr; rq_addr[p] = a; rq_wdata[p] = d; pending[p] = 1'b1;
  endtask

  task automatic new_req(input int p);
    logic [15:0] a;
    case ($urandom_range(0, 3))
      0: a = 16'h1234;
      1: a = 16'hFFFF;
      2: a = 16'h0000;
      default: a = {12'h5A0, 4'($urandom_range(0, 15))};
    endcase
    set_req(p, 1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  // One clock: advance the model over the edge, compare every output, then
  // update the requesters for the next edge.
  task automatic step();
    int   done_p;
    int   win;
    logic strobe;
    done_p = -1;
    @(posedge clk);
    #1;
    cyc++;
    if (m_k == 0) begin
      if (rq_req[0] || rq_req[1]) begin
        if (rq_req[0] && rq_req[1]) win = FIXED ? 0 : 1 - last;
        else win = rq_req[1] ? 1 : 0;
        last = win; t_port = win;
        t_wr = rq_wr[win]; t_addr = rq_addr[win]; t_wdata = rq_wdata[win];
        m_k = 1;
        grant_port_q.push_back(win);
        grant_cyc_q.push_back(cyc);
      end
    end else if (m_k == W + 2) begin
      done_p = t_port;
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == W + 2) begin
        if (t_wr) ref_mem[t_addr] = t_wdata;
        else exp_rd[t_port] = ref_mem[t_addr];
      end
    end

    strobe = (m_k >= 2) && (m_k <= W + 1);
    chk("busy",   32'(busy),     32'(m_k != 0));
    chk("cs",     32'(mem_cs),   32'(m_k != 0));
    chk("we",     32'(mem_we),   32'(strobe && t_wr));
    chk("oe",     32'(mem_oe),   32'(strobe && !t_wr));
    chk("ack0",   32'(p0_ack),   32'(m_k == W + 2 && t_port == 0));
    chk("ack1",   32'(p1_ack),   32'(m_k == W + 2 && t_port == 1));
    chk("rdata0", 32'(p0_rdata), 32'(exp_rd[0]));
    chk("rdata1", 32'(p1_rdata), 32'(exp_rd[1]));
    if (m_k != 0) chk("addr", 32'(mem_addr), 32'(t_addr));
    if (m_k != 0 && t_wr) chk("wdata_bus", 32'(mem_data), 32'(t_wdata));

    if (mem_we) begin we_cnt++; sram[mem_addr] = mem_data; end
    if (mem_oe) oe_cnt++;
    if (p0_ack) begin ack_cnt[0]++; ack_cyc[0] = cyc; end
    if (p1_ack) begin ack_cnt[1]++; ack_cyc[1] = cyc; end
    if (m_k == 1) begin setup_data = mem_data; setup_we = mem_we; end
    if (m_k == W + 2) hold_data = mem_data;

    if (done_p >= 0) begin rq_req[done_p] = 1'b0; pending[done_p] = 1'b0; end
    for (int p = 0; p < 2; p++) begin
      if (!pending[p]) begin
        if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) new_req(p);
        else if (mode == 2) begin
          rq_wr[p] = 1'($urandom_range(0, 1)); rq_addr[p] = 16'($urandom); rq_wdata[p] = 8'($urandom);
        end
      end else if (mode == 2 && t_port == p && m_k >= 1 && m_k <= W + 1 && rq_req[p]
                   && $urandom_range(0, 7) == 0) begin
        rq_req[p] = 1'b0;   // early drop after grant; access must still finish
      end
    end
  endtask

  function automatic bit all_idle();
    return (m_k == 0) && !pending[0] && !pending[1] && !rq_req[0] && !rq_req[1];
  endfunction

  task automatic run_idle(input int max);
    int n;
    n = 0;
    do begin step(); n++; end while (!all_idle() && n < max);
    chk("drain_timeout", 32'(all_idle()), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    if (m_k != 0 && t_wr) ref_mem[t_addr] = sram[t_addr];
    m_k = 0; last = 1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    for (int p = 0; p < 2; p++) begin rq_req[p] = 1'b0; pending[p] = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic d1_access(input logic wr, input logic [7:0] data);
    int acks, we_n, oe_n, ovl;
    logic [7:0] rd;
    acks = 0; we_n = 0; oe_n = 0; ovl = 0; rd = 8'h00;
    d1_req = 1'b1; d1_wr = wr; d1_wdata = data;
    for (int n = 0; n < 20 && acks == 0; n++) begin
      @(posedge clk);
      #1;
      if (d1_we) begin we_n++; s1 = d1_data; end
      if (d1_oe) oe_n++;
      if (d1_we && d1_oe) ovl++;
      if (d1_cs) chk("d1_addr", 32'(d1_addr), 32'hFFFF);
      if (d1_ack) begin acks++; rd = d1_rdata; end
    end
    d1_req = 1'b0;   // HOLD cycle: the arbiter does not sample req here
    chk("d1_ack_count", 32'(acks), 32'd1);
    chk("d1_we_cycles", 32'(we_n), wr ? 32'd1 : 32'd0);
    chk("d1_oe_cycles", 32'(oe_n), wr ? 32'd0 : 32'd1);
    chk("d1_overlap",   32'(ovl),  32'd0);
    if (!wr) chk("d1_readback", 32'(rd), 32'h3C);
    @(posedge clk);
    #1;
    chk("d1_idle", 32'(d1_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    s1 = 8'h00;
    d1_req = 1'b0; d1_wr = 1'b0; d1_wdata = 8'h00;
    for (int p = 0; p < 2; p++) begin
      rq_req[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = 16'h0000; rq_wdata[p] = 8'h00;
    end
    m_k = 0; t_port = 0; t_wr = 1'b0; t_addr = 16'h0000; t_wdata = 8'h00;
    cyc = 0; mode = 0;
    clear_obs();
    do_reset();

    // Reset values
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_cs",     32'(mem_cs),   32'd0);
    chk("rst_we",     32'(mem_we),   32'd0);
    chk("rst_oe",     32'(mem_oe),   32'd0);
    chk("rst_ack0",   32'(p0_ack),   32'd0);
    chk("rst_ack1",   32'(p1_ack),   32'd0);
    chk("rst_rdata0", 32'(p0_rdata), 32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);

    // Single write p0 0x1234 <- 0xA5
    clear_obs();
    set_req(0, 1'b1, 16'h1234, 8'hA5);
    run_idle(20);
    chk("wr_we_cycles", 32'(we_cnt), 32'd2);
    chk("wr_ack_count", 32'(ack_cnt[0]), 32'd1);
    // ack cycle starts 3 edges after the edge that left IDLE (W+2 edges after
    // the edge that began the granting IDLE cycle)
    if (grant_cyc_q.size() > 0) chk("wr_ack_latency", 32'(ack_cyc[0] - grant_cyc_q[0]), 32'd3);
    else chk("wr_grant_seen", 32'd0, 32'd1);
    chk("wr_setup_data", 32'(setup_data), 32'hA5);
    chk("wr_setup_we",   32'(setup_we),   32'd0);
    chk("wr_hold_data",  32'(hold_data),  32'hA5);
    chk("wr_sram",       32'(sram[16'h1234]), 32'hA5);

    // Read-back p0 0x1234
    clear_obs();
    set_req(0, 1'b0, 16'h1234, 8'h00);
    run_idle(20);
    chk("rd_oe_cycles", 32'(oe_cnt), 32'd2);
    chk("rd_we_cycles", 32'(we_cnt), 32'd0);
    chk("rd_rdata0",    32'(p0_rdata), 32'hA5);
    chk("rd_rdata1",    32'(p1_rdata), 32'h00);

    // Contention from reset with immediate re-request
    do_reset();
    clear_obs();
    mode = 1;
    new_req(0);
    new_req(1);
    for (int n = 0; n < 80 && grant_port_q.size() < 6; n++) step();
    mode = 0;
    run_idle(40);
    chk("cont_grants", 32'(grant_port_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < grant_port_q.size(); i++) begin
      chk("cont_order", 32'(grant_port_q[i]), FIXED ? 32'd0 : 32'(i % 2));
      if (i > 0) chk("cont_spacing", 32'(grant_cyc_q[i] - grant_cyc_q[i-1]), 32'd5);
    end

    // Late req drop: p1 drops req during SETUP
    clear_obs();
    set_req(1, 1'b1, 16'h4321, 8'h5E);
    step();
    rq_req[1] = 1'b0;
    run_idle(20);
    chk("late_ack_count", 32'(ack_cnt[1]), 32'd1);
    chk("late_grants",    32'(grant_port_q.size()), 32'd1);

    // Asynchronous reset in the middle of a p1 write strobe
    clear_obs();
    set_req(1, 1'b1, 16'h0777, 8'h99);
    step();
    step();
    chk("mid_we_before", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_we",   32'(mem_we), 32'd0);
    chk("async_cs",   32'(mem_cs), 32'd0);
    chk("async_busy", 32'(busy),   32'd0);
    chk("async_ack1", 32'(p1_ack), 32'd0);
    do_reset();
    clear_obs();
    set_req(0, 1'b0, 16'h1234, 8'h00);
    set_req(1, 1'b1, 16'h0777, 8'h99);
    step();
    if (grant_port_q.size() > 0) chk("post_rst_first", 32'(grant_port_q[0]), 32'd0);
    else chk("post_rst_grant_seen", 32'd0, 32'd1);
    run_idle(40);
    chk("post_rst_ack0", 32'(ack_cnt[0]), 32'd1);
    chk("post_rst_ack1", 32'(ack_cnt[1]), 32'd1);

    // Randomized traffic
    mode = 2;
    repeat (600) step();
    mode = 0;
    run_idle(40);

    // Minimum strobe instance: alternating write/read at 0xFFFF
    d1_access(1'b1, 8'h3C);
    d1_access(1'b0, 8'h00);
    d1_access(1'b1, 8'h3C);
    d1_access(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
